// File: rtl/frame_compositor_pkg.sv
// Shared parameters and types for the game-logic / compositor blocks.
// Sprite geometry, player reset positions and colour constants live here.
package frame_compositor_pkg;

  localparam int POSITION_DEPTH     = 10;
  localparam int SPRITE_INDEX_DEPTH = 4;
  localparam int SCREEN_W           = 640;
  localparam int SPRITE_W           = 64;
  localparam int SPRITE_H           = 64;
  localparam int GROUND_Y           = 400;
  localparam int SPRITE_TOP         = GROUND_Y - SPRITE_H;
  localparam int COLOR_DEPTH        = 12;
  localparam int P1_START           = 100;
  localparam int P2_START           = 476;

  localparam int COL_W  = $clog2(SPRITE_W);
  localparam int ROW_W  = $clog2(SPRITE_H);
  localparam int ADDR_W = SPRITE_INDEX_DEPTH + ROW_W + COL_W;

  localparam logic [COLOR_DEPTH-1:0] TRANSPARENT = 12'hF0F;
  localparam logic [COLOR_DEPTH-1:0] BG_COLOR    = 12'h000;

  typedef logic [POSITION_DEPTH-1:0]     pos_t;
  typedef logic [SPRITE_INDEX_DEPTH-1:0] index_t;
  typedef logic [COLOR_DEPTH-1:0]        color_t;
  typedef logic [ADDR_W-1:0]             addr_t;

  typedef struct packed {
    pos_t   pos;
    index_t sprite;
  } player_t;

endpackage

// File: rtl/frame_compositor_sprite_hit_addr.sv
// Stage-0 bounding-box test and sprite-ROM address for one player.
// MIRROR=1 flips the column so the sprite faces left.
module sprite_hit_addr
  import frame_compositor_pkg::*;
#(
  parameter bit MIRROR = 1'b0
) (
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       pixel_valid,
  input  player_t    player,
  output logic       hit,
  output addr_t      addr
);

  logic [POSITION_DEPTH:0] x_ext;
  logic [POSITION_DEPTH:0] left;
  logic [POSITION_DEPTH:0] right;
  logic [COL_W-1:0]        dx;
  logic [COL_W-1:0]        col;
  logic [ROW_W-1:0]        row;

  always_comb begin
    // One extra bit on the right edge so a sprite near the screen edge clips instead of wrapping.
    x_ext = (POSITION_DEPTH+1)'(pixel_x);
    left  = {1'b0, player.pos};
    right = left + (POSITION_DEPTH+1)'(SPRITE_W);
    hit   = pixel_valid
          && (x_ext >= left) && (x_ext < right)
          && (pixel_x < 10'(SCREEN_W))
          && (pixel_y >= 10'(SPRITE_TOP)) && (pixel_y < 10'(GROUND_Y));
    dx    = COL_W'(pixel_x - 10'(player.pos));
    row   = ROW_W'(pixel_y - 10'(SPRITE_TOP));
    col   = MIRROR ? (COL_W'(SPRITE_W - 1) - dx) : dx;
    addr  = {player.sprite, row, col};
  end

endmodule

// File: rtl/frame_compositor.sv
// Snapshots both players at frame boundaries and composites their sprites
// over the background through a fixed 3-cycle pixel pipeline.
module frame_compositor
  import frame_compositor_pkg::*;
(
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [POSITION_DEPTH-1:0]     p1_position,
  input  logic [POSITION_DEPTH-1:0]     p2_position,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p1_sprite,
  input  logic [SPRITE_INDEX_DEPTH-1:0] p2_sprite,
  input  logic                          done_gen,
  input  logic                          frame_start,
  input  logic [9:0]                    pixel_x,
  input  logic [9:0]                    pixel_y,
  input  logic                          pixel_valid,
  output logic [ADDR_W-1:0]             rom1_addr,
  input  logic [COLOR_DEPTH-1:0]        rom1_data,
  output logic [ADDR_W-1:0]             rom2_addr,
  input  logic [COLOR_DEPTH-1:0]        rom2_data,
  output logic [COLOR_DEPTH-1:0]        color_out,
  output logic                          color_valid,
  output logic                          frame_dropped,
  output logic [7:0]                    drop_count
);

  player_t snap1_reg, snap2_reg;
  logic    hit1, hit2;
  addr_t   addr1, addr2;
  addr_t   rom1_addr_reg, rom2_addr_reg;
  logic    hit1_s1_reg, hit2_s1_reg, valid_s1_reg;
  logic    hit1_s2_reg, hit2_s2_reg, valid_s2_reg;
  color_t  color_reg, color_next;
  logic    color_valid_reg;
  logic    frame_dropped_reg;
  logic [7:0] drop_count_reg;

  sprite_hit_addr #(.MIRROR(1'b0)) u_p1 (
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .player(snap1_reg), .hit(hit1), .addr(addr1)
  );

  sprite_hit_addr #(.MIRROR(1'b1)) u_p2 (
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .player(snap2_reg), .hit(hit2), .addr(addr2)
  );

  // Snapshot updates at the edge, so a pixel sharing the frame_start cycle still sees the old one.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      snap1_reg         <= '{pos: pos_t'(P1_START), sprite: '0};
      snap2_reg         <= '{pos: pos_t'(P2_START), sprite: '0};
      frame_dropped_reg <= 1'b0;
      drop_count_reg    <= 8'd0;
    end else begin
      frame_dropped_reg <= frame_start && !done_gen;
      if (frame_start && done_gen) begin
        snap1_reg <= '{pos: p1_position, sprite: p1_sprite};
        snap2_reg <= '{pos: p2_position, sprite: p2_sprite};
      end else if (frame_start && (drop_count_reg != 8'hFF)) begin
        drop_count_reg <= drop_count_reg + 8'd1;
      end
    end
  end

  always_comb begin
    color_next = BG_COLOR;
    if (hit1_s2_reg && (rom1_data != TRANSPARENT)) begin
      color_next = rom1_data;
    end else if (hit2_s2_reg && (rom2_data != TRANSPARENT)) begin
      color_next = rom2_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rom1_addr_reg   <= '0;
      rom2_addr_reg   <= '0;
      hit1_s1_reg     <= 1'b0;
      hit2_s1_reg     <= 1'b0;
      valid_s1_reg    <= 1'b0;
      hit1_s2_reg     <= 1'b0;
      hit2_s2_reg     <= 1'b0;
      valid_s2_reg    <= 1'b0;
      color_reg       <= BG_COLOR;
      color_valid_reg <= 1'b0;
    end else begin
      if (hit1) rom1_addr_reg <= addr1;
      if (hit2) rom2_addr_reg <= addr2;
      hit1_s1_reg     <= hit1;
      hit2_s1_reg     <= hit2;
      valid_s1_reg    <= pixel_valid;
      hit1_s2_reg     <= hit1_s1_reg;
      hit2_s2_reg     <= hit2_s1_reg;
      valid_s2_reg    <= valid_s1_reg;
      color_reg       <= color_next;
      color_valid_reg <= valid_s2_reg;
    end
  end

  assign rom1_addr     = rom1_addr_reg;
  assign rom2_addr     = rom2_addr_reg;
  assign color_out     = color_reg;
  assign color_valid   = color_valid_reg;
  assign frame_dropped = frame_dropped_reg;
  assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_frame_compositor.sv
// Directed and randomized bench for frame_compositor against a per-pixel
// arithmetic model of the compositing rules with a 3-deep expectation queue.
module tb_frame_compositor;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [9:0]  p1_position, p2_position;
  logic [3:0]  p1_sprite, p2_sprite;
  logic        done_gen, frame_start;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid;
  logic [15:0] rom1_addr, rom2_addr;
  logic [11:0] rom1_data, rom2_data;
  logic [11:0] color_out;
  logic        color_valid;
  logic        frame_dropped;
  logic [7:0]  drop_count;

  localparam logic [11:0] TR = 12'hF0F;
  localparam logic [11:0] BG = 12'h000;

  logic [11:0] rom1_mem [0:65535];
  logic [11:0] rom2_mem [0:65535];

  typedef struct {
    logic        v;
    logic [11:0] c;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int m_p1, m_p2, m_s1, m_s2, m_drop, m_addr1, m_addr2;

  always #5 sys_clk = ~sys_clk;

  // Sprite ROMs with one cycle of read latency.
  always @(posedge sys_clk) begin
    rom1_data <= rom1_mem[rom1_addr];
    rom2_data <= rom2_mem[rom2_addr];
  end

  frame_compositor dut (
    .sys_clk(sys_clk), .rst(rst),
    .p1_position(p1_position), .p2_position(p2_position),
    .p1_sprite(p1_sprite), .p2_sprite(p2_sprite),
    .done_gen(done_gen), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .rom1_addr(rom1_addr), .rom1_data(rom1_data),
    .rom2_addr(rom2_addr), .rom2_data(rom2_data),
    .color_out(color_out), .color_valid(color_valid),
    .frame_dropped(frame_dropped), .drop_count(drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, predict, advance, compare.
  task automatic step(input int x, input int y, input bit v, input bit fs, input bit dg, input bit r);
    bit   h1, h2;
    int   a1, a2;
    exp_t e;
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    pixel_valid = v;
    frame_start = fs;
    done_gen    = dg;
    rst         = r;
    h1 = v && x >= m_p1 && x < m_p1 + 64 && x < 640 && y >= 336 && y < 400;
    h2 = v && x >= m_p2 && x < m_p2 + 64 && x < 640 && y >= 336 && y < 400;
    a1 = m_s1 * 4096 + (y - 336) * 64 + (x - m_p1);
    a2 = m_s2 * 4096 + (y - 336) * 64 + (63 - (x - m_p2));
    e.v = v;
    e.c = BG;
    if (h1 && rom1_mem[a1] != TR) e.c = rom1_mem[a1];
    else if (h2 && rom2_mem[a2] != TR) e.c = rom2_mem[a2];
    q.push_back(e);
    if (r) begin
      foreach (q[i]) begin
        q[i].v = 1'b0;
        q[i].c = BG;
      end
    end
    @(posedge sys_clk);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("color_valid", 32'(color_valid), 32'(e.v));
      chk("color_out", 32'(color_out), 32'(e.c));
    end
    if (r) begin
      m_p1 = 100; m_p2 = 476; m_s1 = 0; m_s2 = 0; m_drop = 0;
      m_addr1 = 0; m_addr2 = 0;
    end else begin
      if (h1) m_addr1 = a1;
      if (h2) m_addr2 = a2;
      if (fs && dg) begin
        m_p1 = int'(p1_position); m_p2 = int'(p2_position);
        m_s1 = int'(p1_sprite);   m_s2 = int'(p2_sprite);
      end else if (fs && m_drop < 255) begin
        m_drop++;
      end
    end
    chk("rom1_addr", 32'(rom1_addr), 32'(m_addr1));
    chk("rom2_addr", 32'(rom2_addr), 32'(m_addr2));
    chk("frame_dropped", 32'(frame_dropped), 32'(fs && !dg && !r));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e0;
    int   x, y, px;
    rst = 1'b1; frame_start = 1'b0; done_gen = 1'b0;
    pixel_x = '0; pixel_y = '0; pixel_valid = 1'b0;
    p1_position = 10'd100; p2_position = 10'd476;
    p1_sprite = '0; p2_sprite = '0;
    for (int i = 0; i < 65536; i++) begin
      rom1_mem[i] = ($urandom_range(0, 3) == 0) ? TR : 12'($urandom);
      rom2_mem[i] = ($urandom_range(0, 3) == 0) ? TR : 12'($urandom);
    end
    m_p1 = 100; m_p2 = 476; m_s1 = 0; m_s2 = 0; m_drop = 0; m_addr1 = 0; m_addr2 = 0;
    e0.v = 1'b0; e0.c = BG;
    q.push_back(e0);
    q.push_back(e0);

    // Reset state.
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // First pixel of sprite 1 at its origin.
    rom1_mem[0] = 12'h0F0;
    step(100, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Just outside the box on the left and below ground.
    step(99, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    step(100, 400, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Mirrored player 2 edges.
    step(476, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    step(539, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    step(540, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Overlap priority at (200,350).
    p1_position = 10'd170; p2_position = 10'd180;
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    rom1_mem[14 * 64 + 30] = TR;
    rom2_mem[14 * 64 + 43] = 12'h00F;
    step(200, 350, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    rom1_mem[14 * 64 + 30] = 12'hF00;
    step(200, 350, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Clipping at the right screen edge.
    p1_position = 10'd600; p2_position = 10'd620;
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(639, 340, 1'b1, 1'b0, 1'b0, 1'b0);
    step(610, 399, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Dropped snapshots, then saturation of drop_count.
    p1_position = 10'd100; p2_position = 10'd476;
    step(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    p1_position = 10'd300;
    step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(100, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    step(300, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 300; i++) step(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Reset in the middle of a pixel stream.
    p1_position = 10'd300;
    for (int i = 0; i < 5; i++) step(100 + i, 336, 1'b1, 1'b0, 1'b0, (i == 1));
    idle(3);
    step(100, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    step(539, 336, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Randomized frames, with live inputs also wiggled mid-frame.
    for (int f = 0; f < 40; f++) begin
      p1_position = 10'($urandom_range(0, 639));
      p2_position = 10'($urandom_range(0, 639));
      p1_sprite   = 4'($urandom_range(0, 15));
      p2_sprite   = 4'($urandom_range(0, 15));
      step($urandom_range(0, 639), $urandom_range(320, 410), 1'($urandom_range(0, 1)),
           1'b1, ($urandom_range(0, 3) != 0), 1'b0);
      for (int p = 0; p < 100; p++) begin
        px = ($urandom_range(0, 1) == 0) ? m_p1 : m_p2;
        x  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 639) : px + $urandom_range(0, 70) - 4;
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        y  = $urandom_range(320, 410);
        if (p == 50) begin
          p1_position = 10'($urandom_range(0, 639));
          p1_sprite   = 4'($urandom_range(0, 15));
        end
        step(x, y, ($urandom_range(0, 9) != 0), 1'b0, 1'b0, 1'b0);
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
